wb_grf: RTL

// - Writeback stage plus general register file: consumes MEM/WB pipeline register outputs, selects writeback data, writes GRF.
// - Serves D-stage operand reads through two async read ports with same-cycle W->D internal bypass.
// - Sole writer of the architectural register file; D-stage decode and forwarding read from it.

---
 rtl/wb_grf_if.sv | 25 ++
 rtl/wb_grf.sv | 82 ++++++++
 2 files changed

// File: rtl/wb_grf_if.sv
// rtl/wb_grf_if.sv - W-stage writeback inputs, D-stage read ports and writeback outputs of wb_grf
interface wb_grf_if;
  logic [31:0] Instr_W;
  logic [31:0] ALU_W;
  logic [31:0] DM_W;
  logic [31:0] EXT_W;
  logic [31:0] PC8_W;
  logic [4:0]  WBA_W;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] WD_W;
  logic        WE_W;

  modport master (
    output Instr_W, ALU_W, DM_W, EXT_W, PC8_W, WBA_W, A1, A2,
    input  RD1, RD2, WD_W, WE_W
  );

  modport slave (
    input  Instr_W, ALU_W, DM_W, EXT_W, PC8_W, WBA_W, A1, A2,
    output RD1, RD2, WD_W, WE_W
  );
endinterface

// File: rtl/wb_grf.sv
// rtl/wb_grf.sv - writeback data select plus register file with same-cycle W->D bypass
// Optional retire counter output retire_cnt when WB_RETIRE_CNT_EN is defined.
module wb_grf #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic        clk,
  input  logic        rst,
  wb_grf_if.slave     bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  logic [DW-1:0] grf [NREG];
  logic [DW-1:0] wd;
  logic          we;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          unused_instr;

  assign opcode       = bus.Instr_W[31:26];
  assign funct        = bus.Instr_W[5:0];
  assign unused_instr = ^bus.Instr_W[25:6];

  always_comb begin
    wd = bus.ALU_W;
    case (opcode)
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: wd = bus.DM_W;
      OP_LUI:                              wd = bus.EXT_W;
      OP_JAL:                              wd = bus.PC8_W;
      OP_RTYPE: begin
        if (funct == FN_JALR) begin
          wd = bus.PC8_W;
        end
      end
      default: ;
    endcase
  end

  // Reset suppresses the write and the bypass in the same cycle.
  assign we       = !rst && (bus.WBA_W != 5'd0);
  assign bus.WE_W = we;
  assign bus.WD_W = wd;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        grf[i] <= '0;
      end
    end else if (we) begin
      grf[bus.WBA_W] <= wd;
    end
  end

  assign bus.RD1 = (bus.A1 == 5'd0)                ? '0 :
                   (we && (bus.A1 == bus.WBA_W))    ? wd : grf[bus.A1];
  assign bus.RD2 = (bus.A2 == 5'd0)                ? '0 :
                   (we && (bus.A2 == bus.WBA_W))    ? wd : grf[bus.A2];

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (bus.Instr_W != 32'd0) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule
